// File: rtl/v_elem_sequencer_if.sv
// Command, v_regfile element-port and scalar-lane signals of v_elem_sequencer.
// V_ELEM_MASK_EN adds the v0 mask inputs cmd_vm and mask_v0.
interface v_elem_sequencer_if #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned VL_W = 7
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      cmd_vd;
  logic [4:0]      cmd_vs1;
  logic [4:0]      cmd_vs2;
  logic [VL_W-1:0] cmd_vl;
  logic [2:0]      cmd_sew;
  logic [2:0]      cmd_lmul;
`ifdef V_ELEM_MASK_EN
  logic            cmd_vm;
  logic [VLEN-1:0] mask_v0;
`endif
  logic            busy;
  logic            done;
  logic [2:0]      rf_sew;
  logic [4:0]      el_rd_addr_1;
  logic [4:0]      el_rd_addr_2;
  logic [4:0]      el_addr_1;
  logic [4:0]      el_addr_2;
  logic [31:0]     el_data_1;
  logic [31:0]     el_data_2;
  logic            el_wr_en;
  logic [4:0]      el_reg_wr_addr;
  logic [4:0]      el_wr_addr;
  logic [VLEN-1:0] el_wr_data;
  logic            lane_req_valid;
  logic            lane_req_ready;
  logic [31:0]     lane_op_a;
  logic [31:0]     lane_op_b;
  logic            lane_rsp_valid;
  logic [31:0]     lane_rsp_data;

  modport slave (
`ifdef V_ELEM_MASK_EN
    input  cmd_vm, mask_v0,
`endif
    input  cmd_valid, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, cmd_sew, cmd_lmul,
    input  el_data_1, el_data_2, lane_req_ready, lane_rsp_valid, lane_rsp_data,
    output cmd_ready, busy, done, rf_sew, el_rd_addr_1, el_rd_addr_2, el_addr_1, el_addr_2,
    output el_wr_en, el_reg_wr_addr, el_wr_addr, el_wr_data, lane_req_valid, lane_op_a, lane_op_b
  );

  modport master (
`ifdef V_ELEM_MASK_EN
    output cmd_vm, mask_v0,
`endif
    output cmd_valid, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, cmd_sew, cmd_lmul,
    output el_data_1, el_data_2, lane_req_ready, lane_rsp_valid, lane_rsp_data,
    input  cmd_ready, busy, done, rf_sew, el_rd_addr_1, el_rd_addr_2, el_addr_1, el_addr_2,
    input  el_wr_en, el_reg_wr_addr, el_wr_addr, el_wr_data, lane_req_valid, lane_op_a, lane_op_b
  );
endinterface

// File: rtl/v_elem_sequencer.sv
// Element-serial sequencer: read vs1[e]/vs2[e], hand them to a scalar lane, write result to vd[e].
// Optional V_ELEM_MASK_EN: elements with cmd_vm=0 and mask_v0[e]=0 are skipped in one cycle.
module v_elem_sequencer #(
  parameter int unsigned VLEN = 128,
  parameter int unsigned VL_W = 7
) (
  input logic               clk,
  input logic               nrst,
  v_elem_sequencer_if.slave io_bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  // log2 of elements per register at SEW=8; each SEW step up halves it
  localparam int unsigned EPR_SHIFT_8 = $clog2(VLEN / 8);

  logic [2:0]      r_state;
  logic [4:0]      r_vd, r_vs1, r_vs2;
  logic [VL_W-1:0] r_vl, r_e;
  logic [2:0]      r_sew;
  logic [31:0]     r_rsp;
`ifdef V_ELEM_MASK_EN
  logic            r_vm;
`endif

  logic [2:0]      w_sew_n, w_lmul_sh, w_shift;
  logic [VL_W:0]   w_vlmax;
  logic [VL_W-1:0] w_vl_clamp, w_idx_mask, w_grp, w_idx, w_e_nxt;
  logic            w_active;
  logic [31:0]     w_sew_mask;

  always_comb begin
    w_sew_n = 3'b000;
    case (io_bus.cmd_sew)
      3'b001:  w_sew_n = 3'b001;
      3'b010:  w_sew_n = 3'b010;
      default: w_sew_n = 3'b000;
    endcase
    w_lmul_sh = 3'd0;
    case (io_bus.cmd_lmul)
      3'b001:  w_lmul_sh = 3'd1;
      3'b010:  w_lmul_sh = 3'd2;
      default: w_lmul_sh = 3'd0;
    endcase
    w_vlmax = (VL_W + 1)'(1) << (3'(EPR_SHIFT_8) - w_sew_n + w_lmul_sh);
  end

  assign w_vl_clamp = ({1'b0, io_bus.cmd_vl} > w_vlmax) ? w_vlmax[VL_W-1:0] : io_bus.cmd_vl;
  assign w_shift    = 3'(EPR_SHIFT_8) - r_sew;
  assign w_idx_mask = (VL_W'(1) << w_shift) - VL_W'(1);
  assign w_grp      = r_e >> w_shift;
  assign w_idx      = r_e & w_idx_mask;
  assign w_e_nxt    = r_e + VL_W'(1);
`ifdef V_ELEM_MASK_EN
  assign w_active   = r_vm | io_bus.mask_v0[r_e];
`else
  assign w_active   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_vd    <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vl    <= '0;
      r_e     <= '0;
      r_sew   <= '0;
      r_rsp   <= '0;
`ifdef V_ELEM_MASK_EN
      r_vm    <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.cmd_valid) begin
            r_vd    <= io_bus.cmd_vd;
            r_vs1   <= io_bus.cmd_vs1;
            r_vs2   <= io_bus.cmd_vs2;
            r_vl    <= w_vl_clamp;
            r_sew   <= w_sew_n;
            r_e     <= '0;
`ifdef V_ELEM_MASK_EN
            r_vm    <= io_bus.cmd_vm;
`endif
            r_state <= (w_vl_clamp == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!w_active) begin
            r_e     <= w_e_nxt;
            r_state <= (w_e_nxt == r_vl) ? S_DONE : S_ISSUE;
          end else if (io_bus.lane_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io_bus.lane_rsp_valid) begin
            r_rsp   <= io_bus.lane_rsp_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_e     <= w_e_nxt;
          r_state <= (w_e_nxt == r_vl) ? S_DONE : S_ISSUE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    io_bus.cmd_ready      = (r_state == S_IDLE);
    io_bus.busy           = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
    io_bus.done           = (r_state == S_DONE);
    io_bus.rf_sew         = r_sew;
    io_bus.el_rd_addr_1   = '0;
    io_bus.el_rd_addr_2   = '0;
    io_bus.el_addr_1      = '0;
    io_bus.el_addr_2      = '0;
    io_bus.lane_req_valid = 1'b0;
    io_bus.lane_op_a      = '0;
    io_bus.lane_op_b      = '0;
    io_bus.el_wr_en       = 1'b0;
    io_bus.el_reg_wr_addr = '0;
    io_bus.el_wr_addr     = '0;
    io_bus.el_wr_data     = '0;
    case (r_sew)
      3'b001:  w_sew_mask = 32'h0000_ffff;
      3'b010:  w_sew_mask = 32'hffff_ffff;
      default: w_sew_mask = 32'h0000_00ff;
    endcase
    if (r_state == S_ISSUE) begin
      io_bus.el_rd_addr_1   = r_vs1 + w_grp[4:0];
      io_bus.el_rd_addr_2   = r_vs2 + w_grp[4:0];
      io_bus.el_addr_1      = w_idx[4:0];
      io_bus.el_addr_2      = w_idx[4:0];
      io_bus.lane_req_valid = w_active;
      io_bus.lane_op_a      = io_bus.el_data_1 & w_sew_mask;
      io_bus.lane_op_b      = io_bus.el_data_2 & w_sew_mask;
    end
    if (r_state == S_WRITE) begin
      io_bus.el_wr_en       = 1'b1;
      io_bus.el_reg_wr_addr = r_vd + w_grp[4:0];
      io_bus.el_wr_addr     = w_idx[4:0];
      // regfile slices by rf_sew, so every lane carries the same result
      case (r_sew)
        3'b001:  io_bus.el_wr_data = {(VLEN / 16){r_rsp[15:0]}};
        3'b010:  io_bus.el_wr_data = {(VLEN / 32){r_rsp}};
        default: io_bus.el_wr_data = {(VLEN / 8){r_rsp[7:0]}};
      endcase
    end
  end
endmodule

// File: tb/tb_v_elem_sequencer.sv
// Bench for v_elem_sequencer: regfile stand-in, adder lane with programmable delays, element model.
module tb_v_elem_sequencer;
  localparam int unsigned VLEN = 128;
  localparam int unsigned VL_W = 7;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  v_elem_sequencer_if #(.VLEN(VLEN), .VL_W(VL_W)) bus ();

  v_elem_sequencer #(.VLEN(VLEN), .VL_W(VL_W)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .io_bus (bus)
  );

  typedef struct {
    logic [4:0]      rr1, rr2, ri, wr;
    logic [31:0]     a, b;
    logic [VLEN-1:0] d;
  } el_t;

  el_t             q[$];
  el_t             cur;
  logic [VLEN-1:0] regs [32];
  logic [VLEN-1:0] wmask;
  int   cyc = 0;
  int   n_vec = 0, n_err = 0, n_wr = 0, last_done = -1;
  int   acc = -100, done_c = -100, rst_at = 1 << 30;
  int   rdly = 0, sdly = 0, cnt = 0, wcnt = 0;
  bit   inject = 1'b0, chk_en = 1'b0, rf_init = 1'b0, waiting = 1'b0;
  logic [31:0] hold_a, hold_b;

  always @(posedge clk) cyc <= cyc + 1;

  // regfile stand-in: combinational element reads sliced by rf_sew
  logic [9:0]  w_sewb;
  logic [31:0] w_emask;
  assign w_sewb  = (bus.rf_sew == 3'd1) ? 10'd16 : (bus.rf_sew == 3'd2) ? 10'd32 : 10'd8;
  assign w_emask = (bus.rf_sew == 3'd1) ? 32'hffff :
                   (bus.rf_sew == 3'd2) ? 32'hffff_ffff : 32'hff;
  assign bus.el_data_1 = 32'(regs[bus.el_rd_addr_1] >> (10'(bus.el_addr_1) * w_sewb)) & w_emask;
  assign bus.el_data_2 = 32'(regs[bus.el_rd_addr_2] >> (10'(bus.el_addr_2) * w_sewb)) & w_emask;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] init_val(input int r);
    logic [VLEN-1:0] v;
    v = '0;
    if (r == 1) v = {32'd4, 32'd3, 32'd2, 32'd1};
    else if (r == 2) v = {32'd40, 32'd30, 32'd20, 32'd10};
    else for (int j = 0; j < 16; j++) v = v | (VLEN'((r % 16) * 16 + j) << (j * 8));
    return v;
  endfunction

  // Element list and completion time straight from the command's arithmetic meaning
  task automatic model_cmd(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                           input int vl, input logic [2:0] sew, input logic [2:0] lmul,
                           input logic vm, input logic [VLEN-1:0] m0, output int cycles);
    int sewb, lm, epr, n, idx, grp;
    logic [31:0] msk, res;
    el_t el;
    sewb = (sew == 3'd1) ? 16 : (sew == 3'd2) ? 32 : 8;
    lm   = (lmul == 3'd1) ? 2 : (lmul == 3'd2) ? 4 : 1;
    msk  = (sewb == 32) ? 32'hffff_ffff : ((32'd1 << sewb) - 32'd1);
    epr  = VLEN / sewb;
    n    = (vl > epr * lm) ? epr * lm : vl;
    cycles = 1;
    for (int e = 0; e < n; e++) begin
      idx = e % epr;
      grp = e / epr;
      if (!vm && !m0[e]) begin
        cycles += 1;
        continue;
      end
      el.rr1 = 5'((int'(vs1) + grp) % 32);
      el.rr2 = 5'((int'(vs2) + grp) % 32);
      el.wr  = 5'((int'(vd) + grp) % 32);
      el.ri  = 5'(idx);
      el.a   = 32'(regs[el.rr1] >> (idx * sewb)) & msk;
      el.b   = 32'(regs[el.rr2] >> (idx * sewb)) & msk;
      res    = (el.a + el.b) & msk;
      el.d   = '0;
      for (int k = 0; k < epr; k++) el.d = el.d | (VLEN'(res) << (k * sewb));
      q.push_back(el);
      cycles += rdly + sdly + 3;
    end
  endtask

  task automatic issue(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input int vl, input logic [2:0] sew, input logic [2:0] lmul,
                       input int rd, input int sd, input bit inj,
                       input logic vm, input logic [VLEN-1:0] m0);
    int ncyc;
    @(posedge clk); #1;
    rdly = rd; sdly = sd; inject = inj;
    bus.cmd_vd = vd; bus.cmd_vs1 = vs1; bus.cmd_vs2 = vs2;
    bus.cmd_vl = VL_W'(vl); bus.cmd_sew = sew; bus.cmd_lmul = lmul;
`ifdef V_ELEM_MASK_EN
    bus.cmd_vm = vm; bus.mask_v0 = m0;
`endif
    bus.cmd_valid = 1'b1;
    model_cmd(vd, vs1, vs2, vl, sew, lmul, vm, m0, ncyc);
    acc = cyc; done_c = cyc + ncyc; rst_at = 1 << 30;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input string name);
    while (cyc <= done_c + 1) begin @(posedge clk); #1; end
    chk({name, " elements left"}, VLEN'(q.size()), '0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, " cmd_ready"}, VLEN'(bus.cmd_ready), VLEN'(1));
    chk({name, " busy"}, VLEN'(bus.busy), '0);
    chk({name, " done"}, VLEN'(bus.done), '0);
    chk({name, " el_wr_en"}, VLEN'(bus.el_wr_en), '0);
    chk({name, " lane_req_valid"}, VLEN'(bus.lane_req_valid), '0);
    chk({name, " rf_sew"}, VLEN'(bus.rf_sew), '0);
    chk({name, " addrs"}, VLEN'({bus.el_rd_addr_1, bus.el_rd_addr_2, bus.el_addr_1,
                                 bus.el_addr_2, bus.el_reg_wr_addr, bus.el_wr_addr}), '0);
    chk({name, " wr_data"}, bus.el_wr_data, '0);
    chk({name, " lane ops"}, VLEN'({bus.lane_op_a, bus.lane_op_b}), '0);
  endtask

  // Single compare process: status vs timeline, requests/writes vs model, plus lane behaviour
  always @(negedge clk) begin
    if (!rf_init) begin
      for (int r = 0; r < 32; r++) regs[r] = init_val(r);
      rf_init = 1'b1;
    end
    if (!nrst) begin
      waiting = 1'b0; cnt = 0; wcnt = 0;
      bus.lane_req_ready = 1'b0; bus.lane_rsp_valid = 1'b0;
    end else if (chk_en) begin
      chk("busy", VLEN'(bus.busy), VLEN'(cyc > acc && cyc < done_c && cyc <= rst_at));
      chk("done", VLEN'(bus.done), VLEN'(cyc == done_c && cyc <= rst_at));
      chk("cmd_ready", VLEN'(bus.cmd_ready), VLEN'(!(cyc > acc && cyc <= done_c) || cyc > rst_at));
      if (bus.done) last_done = cyc;
      if (bus.el_wr_en) begin
        if (q.size() == 0) chk("spurious write", VLEN'(bus.el_wr_en), '0);
        else begin
          cur = q.pop_front();
          chk("wr reg", VLEN'(bus.el_reg_wr_addr), VLEN'(cur.wr));
          chk("wr idx", VLEN'(bus.el_wr_addr), VLEN'(cur.ri));
          chk("wr data", bus.el_wr_data, cur.d);
          wmask = VLEN'(w_emask) << (10'(bus.el_wr_addr) * w_sewb);
          regs[bus.el_reg_wr_addr] = (regs[bus.el_reg_wr_addr] & ~wmask) | (bus.el_wr_data & wmask);
          n_wr++;
        end
      end
      bus.lane_req_ready = 1'b0;
      bus.lane_rsp_valid = 1'b0;
      if (waiting) begin
        if (wcnt == sdly) begin
          bus.lane_rsp_valid = 1'b1;
          bus.lane_rsp_data  = hold_a + hold_b;
          waiting = 1'b0; wcnt = 0;
        end else wcnt++;
      end else if (bus.lane_req_valid) begin
        if (cnt == 0) begin
          if (q.size() == 0) chk("spurious request", VLEN'(bus.lane_req_valid), '0);
          else begin
            chk("rd addr 1", VLEN'(bus.el_rd_addr_1), VLEN'(q[0].rr1));
            chk("rd addr 2", VLEN'(bus.el_rd_addr_2), VLEN'(q[0].rr2));
            chk("op_a", VLEN'(bus.lane_op_a), VLEN'(q[0].a));
            chk("op_b", VLEN'(bus.lane_op_b), VLEN'(q[0].b));
          end
          hold_a = bus.lane_op_a; hold_b = bus.lane_op_b;
        end else begin
          chk("op_a stable", VLEN'(bus.lane_op_a), VLEN'(hold_a));
          chk("op_b stable", VLEN'(bus.lane_op_b), VLEN'(hold_b));
        end
        if (cnt == rdly) begin
          bus.lane_req_ready = 1'b1;
          waiting = 1'b1; cnt = 0;
        end else begin
          cnt++;
          if (inject) begin
            bus.lane_rsp_valid = 1'b1;
            bus.lane_rsp_data  = 32'hdead_beef;
          end
        end
      end
    end
  end

  int base, saved_done;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_vd = '0; bus.cmd_vs1 = '0; bus.cmd_vs2 = '0;
    bus.cmd_vl = '0; bus.cmd_sew = '0; bus.cmd_lmul = '0;
`ifdef V_ELEM_MASK_EN
    bus.cmd_vm = 1'b1; bus.mask_v0 = '0;
`endif
    bus.lane_req_ready = 1'b0; bus.lane_rsp_valid = 1'b0; bus.lane_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk_idle("reset");

    // T1: sew32 lmul1 vl4, v3 = v1 + v2
    base = n_wr;
    issue(5'd3, 5'd1, 5'd2, 4, 3'b010, 3'b000, 0, 0, 1'b0, 1'b1, '0);
    finish_cmd("T1");
    chk("T1 writes", VLEN'(n_wr - base), VLEN'(4));
    chk("T1 done cycle", VLEN'(last_done - acc), VLEN'(13));
    chk("T1 v3", regs[3], {32'd44, 32'd33, 32'd22, 32'd11});

    // T2: sew8 lmul2 vl20 into v30/v31
    base = n_wr;
    issue(5'd30, 5'd4, 5'd6, 20, 3'b000, 3'b001, 0, 0, 1'b0, 1'b1, '0);
    finish_cmd("T2");
    chk("T2 writes", VLEN'(n_wr - base), VLEN'(20));
    chk("T2 done cycle", VLEN'(last_done - acc), VLEN'(61));
    chk("T2 v30 byte0", VLEN'(regs[30][7:0]), VLEN'(8'hA0));
    chk("T2 v31 byte3", VLEN'(regs[31][31:24]), VLEN'(8'hC6));

    // T3: vl0
    base = n_wr;
    issue(5'd9, 5'd1, 5'd2, 0, 3'b010, 3'b000, 0, 0, 1'b0, 1'b1, '0);
    finish_cmd("T3");
    chk("T3 writes", VLEN'(n_wr - base), '0);
    chk("T3 done cycle", VLEN'(last_done - acc), VLEN'(1));

    // T4: slow lane, stray responses during ISSUE, cmd_valid while busy
    base = n_wr;
    issue(5'd12, 5'd8, 5'd10, 3, 3'b001, 3'b000, 5, 3, 1'b1, 1'b1, '0);
    repeat (3) @(posedge clk);
    #1 bus.cmd_valid = 1'b1; bus.cmd_vl = VL_W'(1); bus.cmd_vd = 5'd0;
    repeat (10) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    finish_cmd("T4");
    chk("T4 writes", VLEN'(n_wr - base), VLEN'(3));
    chk("T4 done cycle", VLEN'(last_done - acc), VLEN'(34));
    inject = 1'b0;

    // T5: reset during WAIT of element 2
    base = n_wr;
    saved_done = last_done;
    issue(5'd16, 5'd1, 5'd2, 4, 3'b010, 3'b000, 0, 0, 1'b0, 1'b1, '0);
    while (cyc < acc + 8) begin @(posedge clk); #1; end
    nrst = 1'b0;
    rst_at = cyc;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    chk_idle("T5 after reset");
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (20) @(posedge clk);
    chk("T5 writes", VLEN'(n_wr - base), VLEN'(2));
    chk("T5 no done", VLEN'(last_done), VLEN'(saved_done));

    // T7: vl clamp (100 -> 16) with register wrap v31 -> v0..v2
    base = n_wr;
    issue(5'd20, 5'd31, 5'd8, 100, 3'b010, 3'b010, 0, 0, 1'b0, 1'b1, '0);
    finish_cmd("T7");
    chk("T7 writes", VLEN'(n_wr - base), VLEN'(16));
    chk("T7 done cycle", VLEN'(last_done - acc), VLEN'(49));

    // T8: illegal sew/lmul codes -> sew8 lmul1, vl 20 -> 16
    base = n_wr;
    issue(5'd24, 5'd4, 5'd6, 20, 3'b111, 3'b101, 0, 0, 1'b0, 1'b1, '0);
    finish_cmd("T8");
    chk("T8 writes", VLEN'(n_wr - base), VLEN'(16));
    chk("T8 done cycle", VLEN'(last_done - acc), VLEN'(49));

`ifdef V_ELEM_MASK_EN
    // T6: masked elements 1 and 3 skipped
    base = n_wr;
    issue(5'd5, 5'd1, 5'd2, 4, 3'b010, 3'b000, 0, 0, 1'b0, 1'b0, VLEN'(4'b0101));
    finish_cmd("T6");
    chk("T6 writes", VLEN'(n_wr - base), VLEN'(2));
    chk("T6 done cycle", VLEN'(last_done - acc), VLEN'(9));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
